// File: rtl/lsu_bus_if.sv
// Load/store unit between the RV32I datapath and a req/ack data bus.
// One access at a time: IDLE -> BUSY (wait for ack or timeout) -> DONE.
module lsu_bus_if #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        func3_reg;
    logic [1:0]        off_reg;
    logic [31:0]       rdata_reg;

    logic              req;
    logic              bad_f3;
    logic              misalign;
    logic              fault_now;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [7:0]        rd_byte [0:3];
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_ext;

    assign req = mem_rd | mem_wr;

    // A store wins when both requests are high, so legality follows mem_wr.
    always_comb begin
        bad_f3 = 1'b0;
        if (mem_wr) begin
            bad_f3 = !(func3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_f3 = func3 inside {3'b011, 3'b110, 3'b111};
        end
        misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                   ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    assign fault_now    = req & (bad_f3 | misalign);
    assign access_fault = (state_reg == IDLE) & fault_now;
    assign stall        = (state_reg == BUSY) | ((state_reg == IDLE) & req & ~fault_now);
    // A faulting access must not write stale load data into the regfile.
    assign rdata        = access_fault ? 32'h0 : rdata_reg;

    always_comb begin
        case (func3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_byte[off_reg];
    assign sel_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (func3_reg)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'h0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'h0, sel_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            func3_reg <= 3'b000;
            off_reg   <= 2'b00;
            rdata_reg <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !fault_now) begin
                        func3_reg <= func3;
                        off_reg   <= addr[1:0];
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        bus_we    <= mem_wr;
                        bus_req   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // Ack takes priority over a timeout in the same cycle.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata_reg <= load_ext;
                        end
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        bus_req   <= 1'b0;
                        rdata_reg <= 32'h0;
                        bus_err   <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bus_err   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: expected load results and error flags are
// queued when an access is issued and checked when the unit reaches DONE.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        access_fault;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    lsu_bus_if #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .func3(func3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .access_fault(access_fault), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Runs one legal access; ack_at is the BUSY cycle (1-based) carrying the ack, 0 = never.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rword, input int exp_busy,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   stall_cnt;
        int   cyc;
        bit   done;
        mem_rd = rd; mem_wr = wr; func3 = f3; addr = a; wdata = wd;
        e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
        chk({tag, ".idle_fault"}, 32'(access_fault), 32'd0);
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            cyc++;
            if (cyc == ack_at) begin
                bus_ack = 1'b1;
                bus_rdata = rword;
            end
            @(negedge clk);
            if (stall) stall_cnt++;
            else done = 1;
            if (cyc == 1) begin
                chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
                chk({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
                chk({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
                chk({tag, ".bus_be"}, 32'(bus_be), 32'(exp_be));
                chk({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
            end
            if (!done) begin
                @(posedge clk); #1;
                bus_ack = 1'b0;
            end
        end
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_busy + 1));
        chk({tag, ".done_req"}, 32'(bus_req), 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".rdata"}, rdata, e.rdata);
            chk({tag, ".bus_err"}, 32'(bus_err), 32'(e.err));
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".err_cleared"}, 32'(bus_err), 32'd0);
        $display("txn %s addr=%h rdata=%h stall_cycles=%0d", tag, a, rdata, stall_cnt);
    endtask

    task automatic fault(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a);
        mem_rd = rd; mem_wr = wr; func3 = f3; addr = a; wdata = 32'h55AA55AA;
        @(negedge clk);
        chk({tag, ".access_fault"}, 32'(access_fault), 32'd1);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".rdata"}, rdata, 32'h0);
        @(posedge clk); #1;
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd0);
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        chk({tag, ".no_req"}, 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        $display("txn %s addr=%h faulted", tag, a);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.bus_we", 32'(bus_we), 32'd0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk("rst.bus_be", 32'(bus_be), 32'd0);
        chk("rst.bus_wdata", bus_wdata, 32'h0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Stores: tag, rd, wr, f3, addr, wdata, ack_at, rword, busy, be, bus_wdata, rdata, err
        access("sw",  0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0, 2, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        access("sb",  0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
        access("sh",  0, 1, 3'b001, 32'h102, 32'h0000BEEF, 1, 32'h0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0);

        // Loads with sign/zero extension
        access("lb",  1, 0, 3'b000, 32'h201, 32'h0, 1, 32'h123480FF, 1, 4'b0010, 32'h0, 32'hFFFFFF80, 0);
        access("lbu", 1, 0, 3'b100, 32'h201, 32'h0, 1, 32'h123480FF, 1, 4'b0010, 32'h0, 32'h00000080, 0);
        access("lh",  1, 0, 3'b001, 32'h202, 32'h0, 2, 32'h123480FF, 2, 4'b1100, 32'h0, 32'h00001234, 0);
        access("lw",  1, 0, 3'b010, 32'h200, 32'h0, 3, 32'h123480FF, 3, 4'b1111, 32'h0, 32'h123480FF, 0);
        access("lhu", 1, 0, 3'b101, 32'h200, 32'h0, 1, 32'h12348001, 1, 4'b0011, 32'h0, 32'h00008001, 0);

        // Faults
        fault("lw_mis",  1, 0, 3'b010, 32'h102);
        fault("st_f011", 0, 1, 3'b011, 32'h100);
        fault("lh_mis",  1, 0, 3'b001, 32'h201);
        fault("ld_f110", 1, 0, 3'b110, 32'h100);

        // Timeout, then ack on the timeout cycle
        access("lw_to",  1, 0, 3'b010, 32'h300, 32'h0, 0,  32'h0,      16, 4'b1111, 32'h0, 32'h0,      1);
        access("lw_ack16", 1, 0, 3'b010, 32'h304, 32'h0, 16, 32'hCAFEF00D, 16, 4'b1111, 32'h0, 32'hCAFEF00D, 0);

        // Reset in the middle of BUSY
        mem_rd = 1'b1; func3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid.req_before", 32'(bus_req), 32'd1);
        reset = 1'b1; mem_rd = 1'b0;
        #1;
        chk("rstmid.bus_req", 32'(bus_req), 32'd0);
        chk("rstmid.stall", 32'(stall), 32'd0);
        chk("rstmid.rdata", rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Stray ack in IDLE
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stray.bus_req", 32'(bus_req), 32'd0);
        chk("stray.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("stray.rdata", rdata, 32'h0);
        chk("stray.bus_err", 32'(bus_err), 32'd0);

        access("lw_after", 1, 0, 3'b010, 32'h404, 32'h0, 1, 32'h5A5A1234, 1, 4'b1111, 32'h0, 32'h5A5A1234, 0);
        // Both requests high: the store wins and rdata is untouched
        access("rdwr", 1, 1, 3'b010, 32'h408, 32'h11223344, 1, 32'h0, 1, 4'b1111, 32'h11223344, 32'h5A5A1234, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
